// File: rtl/clock_mode_ctrl_if.sv
// Pushbutton inputs and control outputs of the clock/stopwatch UI sequencer.
// master = top-level/bench side, slave = clock_mode_ctrl.
interface clock_mode_ctrl_if;
    logic       Btn_Mode;
    logic       Btn_Up;
    logic       Btn_Down;
    logic       Control;
    logic       LoadTime;
    logic       LoadAlm;
    logic       AlarmEnable;
    logic [3:0] SetHours;
    logic [5:0] SetMins;
    logic [5:0] SetSecs;
    logic       Set_AM_PM;
    logic [3:0] AlarmHoursIn;
    logic [5:0] AlarmMinsIn;
    logic       Alarm_AM_PM_In;
    logic       Start_S;
    logic       Stop_S;
    logic       Reset_S;
    logic [3:0] Mode_State;

    modport master (
        output Btn_Mode, Btn_Up, Btn_Down,
        input  Control, LoadTime, LoadAlm, AlarmEnable,
        input  SetHours, SetMins, SetSecs, Set_AM_PM,
        input  AlarmHoursIn, AlarmMinsIn, Alarm_AM_PM_In,
        input  Start_S, Stop_S, Reset_S, Mode_State
    );

    modport slave (
        input  Btn_Mode, Btn_Up, Btn_Down,
        output Control, LoadTime, LoadAlm, AlarmEnable,
        output SetHours, SetMins, SetSecs, Set_AM_PM,
        output AlarmHoursIn, AlarmMinsIn, Alarm_AM_PM_In,
        output Start_S, Stop_S, Reset_S, Mode_State
    );
endinterface

// File: rtl/clock_mode_ctrl.sv
// Button-driven mode sequencer: debounces Mode/Up/Down and edits time, alarm
// and stopwatch controls for the digital clock top level.
module clock_mode_ctrl #(
    parameter int DEB_CYCLES = 50,
    parameter int CNT_W      = 6
) (
    input  logic              Clock_5K,
    input  logic              Reset,
    clock_mode_ctrl_if.slave  ui
);
    typedef enum logic [3:0] {
        CLOCK     = 4'd0,
        T_HOUR    = 4'd1,
        T_MIN     = 4'd2,
        T_SEC     = 4'd3,
        T_AMPM    = 4'd4,
        A_HOUR    = 4'd5,
        A_MIN     = 4'd6,
        A_AMPM    = 4'd7,
        STOPWATCH = 4'd8
    } mode_t;

    // bit 0 = Mode, bit 1 = Up, bit 2 = Down
    logic [2:0]       btn_raw, sync1, sync2, deb, deb_d, press;
    logic [CNT_W-1:0] deb_cnt [3];

    assign btn_raw = {ui.Btn_Down, ui.Btn_Up, ui.Btn_Mode};

    always_ff @(posedge Clock_5K) begin
        if (!Reset) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            deb_d <= '0;
            for (int unsigned i = 0; i < 3; i++) deb_cnt[i] <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            deb_d <= deb;
            // flip only after DEB_CYCLES+1 consecutive disagreeing samples
            for (int unsigned i = 0; i < 3; i++) begin
                if (sync2[i] == deb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == CNT_W'(DEB_CYCLES)) begin
                    deb[i]     <= ~deb[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign press = deb & ~deb_d;

    logic mode_ev, up_ev, dn_ev;
    assign mode_ev = press[0];
    assign up_ev   = press[1] & ~press[2];
    assign dn_ev   = press[2] & ~press[1];

    function automatic logic [3:0] hour_step(input logic [3:0] h, input logic up);
        if (up) return (h == 4'd12) ? 4'd1 : h + 4'd1;
        return (h == 4'd1) ? 4'd12 : h - 4'd1;
    endfunction

    function automatic logic [5:0] sixty_step(input logic [5:0] v, input logic up);
        if (up) return (v == 6'd59) ? 6'd0 : v + 6'd1;
        return (v == 6'd0) ? 6'd59 : v - 6'd1;
    endfunction

    mode_t      state, nxt_mode;
    logic       control, load_time, load_alm, alarm_en, running;
    logic [3:0] set_hours, alm_hours;
    logic [5:0] set_mins, set_secs, alm_mins;
    logic       set_ampm, alm_ampm;
    logic       start_s, stop_s, reset_s;

    always_comb begin
        nxt_mode = (state == STOPWATCH) ? CLOCK : mode_t'(4'(state) + 4'd1);
    end

    always_ff @(posedge Clock_5K) begin
        if (!Reset) begin
            state     <= CLOCK;
            control   <= 1'b1;
            load_time <= 1'b0;
            load_alm  <= 1'b0;
            alarm_en  <= 1'b0;
            set_hours <= 4'd12;
            set_mins  <= '0;
            set_secs  <= '0;
            set_ampm  <= 1'b0;
            alm_hours <= 4'd12;
            alm_mins  <= '0;
            alm_ampm  <= 1'b0;
            running   <= 1'b0;
            start_s   <= 1'b0;
            stop_s    <= 1'b0;
            reset_s   <= 1'b0;
        end else begin
            start_s <= 1'b0;
            stop_s  <= 1'b0;
            reset_s <= 1'b0;
            if (mode_ev) begin
                state     <= nxt_mode;
                control   <= (nxt_mode != STOPWATCH);
                load_time <= (nxt_mode inside {T_HOUR, T_MIN, T_SEC, T_AMPM});
                load_alm  <= (nxt_mode inside {A_HOUR, A_MIN, A_AMPM});
                // a running stopwatch is stopped on the way out
                if (state == STOPWATCH && running) begin
                    stop_s  <= 1'b1;
                    running <= 1'b0;
                end
            end else if (up_ev || dn_ev) begin
                case (state)
                    CLOCK:  if (up_ev) alarm_en <= ~alarm_en;
                    T_HOUR: set_hours <= hour_step(set_hours, up_ev);
                    T_MIN:  set_mins  <= sixty_step(set_mins, up_ev);
                    T_SEC:  set_secs  <= sixty_step(set_secs, up_ev);
                    T_AMPM: set_ampm  <= ~set_ampm;
                    A_HOUR: alm_hours <= hour_step(alm_hours, up_ev);
                    A_MIN:  alm_mins  <= sixty_step(alm_mins, up_ev);
                    A_AMPM: alm_ampm  <= ~alm_ampm;
                    STOPWATCH: begin
                        if (up_ev) begin
                            start_s <= ~running;
                            stop_s  <= running;
                            running <= ~running;
                        end else if (!running) begin
                            reset_s <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign ui.Control        = control;
    assign ui.LoadTime       = load_time;
    assign ui.LoadAlm        = load_alm;
    assign ui.AlarmEnable    = alarm_en;
    assign ui.SetHours       = set_hours;
    assign ui.SetMins        = set_mins;
    assign ui.SetSecs        = set_secs;
    assign ui.Set_AM_PM      = set_ampm;
    assign ui.AlarmHoursIn   = alm_hours;
    assign ui.AlarmMinsIn    = alm_mins;
    assign ui.Alarm_AM_PM_In = alm_ampm;
    assign ui.Start_S        = start_s;
    assign ui.Stop_S         = stop_s;
    assign ui.Reset_S        = reset_s;
    assign ui.Mode_State     = state;
endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Scoreboarded bench for clock_mode_ctrl: a reference model predicts the full
// output snapshot for every button action, checked once the buttons settle.
module tb_clock_mode_ctrl;
    localparam int DEB = 4;

    logic Clock_5K = 1'b0;
    logic Reset    = 1'b0;

    clock_mode_ctrl_if ui();

    clock_mode_ctrl #(.DEB_CYCLES(DEB), .CNT_W(6)) dut (
        .Clock_5K (Clock_5K),
        .Reset    (Reset),
        .ui       (ui)
    );

    always #5 Clock_5K = ~Clock_5K;

    typedef struct packed {
        logic [3:0] st;
        logic       ctl, lt, la, aen;
        logic [3:0] h;
        logic [5:0] m, s;
        logic       ap;
        logic [3:0] ah;
        logic [5:0] am;
        logic       aap;
        logic [7:0] n_start, n_stop, n_reset;
    } snap_t;

    int    checks = 0;
    int    errors = 0;
    string cur_name = "none";
    snap_t sb[$];
    event  settled;

    // reference model state
    int m_st, m_h, m_m, m_s, m_ah, m_am;
    bit m_aen, m_ap, m_aap, m_run;
    int m_start = 0, m_stop = 0, m_reset = 0;

    // observed pulse counts
    int   act_start = 0, act_stop = 0, act_reset = 0;
    logic p_start = 1'b0, p_stop = 1'b0, p_reset = 1'b0;

    function automatic void model_reset();
        m_st = 0; m_aen = 0; m_run = 0;
        m_h = 12; m_m = 0; m_s = 0; m_ap = 0;
        m_ah = 12; m_am = 0; m_aap = 0;
    endfunction

    function automatic void model_press(input logic [2:0] b);
        bit mo, up, dn;
        mo = b[0];
        up = b[1] & ~b[2];
        dn = b[2] & ~b[1];
        if (mo) begin
            if (m_st == 8 && m_run) begin m_stop++; m_run = 0; end
            m_st = (m_st == 8) ? 0 : m_st + 1;
        end else if (up || dn) begin
            case (m_st)
                0: if (up) m_aen = !m_aen;
                1: m_h  = up ? ((m_h == 12) ? 1 : m_h + 1) : ((m_h == 1) ? 12 : m_h - 1);
                2: m_m  = up ? (m_m + 1) % 60 : (m_m + 59) % 60;
                3: m_s  = up ? (m_s + 1) % 60 : (m_s + 59) % 60;
                4: m_ap = !m_ap;
                5: m_ah = up ? ((m_ah == 12) ? 1 : m_ah + 1) : ((m_ah == 1) ? 12 : m_ah - 1);
                6: m_am = up ? (m_am + 1) % 60 : (m_am + 59) % 60;
                7: m_aap = !m_aap;
                8: begin
                    if (up) begin
                        if (m_run) begin m_stop++; m_run = 0; end
                        else begin m_start++; m_run = 1; end
                    end else if (!m_run) begin
                        m_reset++;
                    end
                end
                default: ;
            endcase
        end
    endfunction

    function automatic snap_t snap_model();
        snap_t x;
        x.st  = 4'(m_st);
        x.ctl = (m_st != 8);
        x.lt  = (m_st >= 1 && m_st <= 4);
        x.la  = (m_st >= 5 && m_st <= 7);
        x.aen = m_aen;
        x.h   = 4'(m_h);
        x.m   = 6'(m_m);
        x.s   = 6'(m_s);
        x.ap  = m_ap;
        x.ah  = 4'(m_ah);
        x.am  = 6'(m_am);
        x.aap = m_aap;
        x.n_start = 8'(m_start);
        x.n_stop  = 8'(m_stop);
        x.n_reset = 8'(m_reset);
        return x;
    endfunction

    function automatic snap_t snap_dut();
        snap_t x;
        x.st  = ui.Mode_State;
        x.ctl = ui.Control;
        x.lt  = ui.LoadTime;
        x.la  = ui.LoadAlm;
        x.aen = ui.AlarmEnable;
        x.h   = ui.SetHours;
        x.m   = ui.SetMins;
        x.s   = ui.SetSecs;
        x.ap  = ui.Set_AM_PM;
        x.ah  = ui.AlarmHoursIn;
        x.am  = ui.AlarmMinsIn;
        x.aap = ui.Alarm_AM_PM_In;
        x.n_start = 8'(act_start);
        x.n_stop  = 8'(act_stop);
        x.n_reset = 8'(act_reset);
        return x;
    endfunction

    // pulse monitor: counts pulses, flags overlap or widths above one cycle
    always @(negedge Clock_5K) begin
        if (ui.Start_S || ui.Stop_S || ui.Reset_S) begin
            checks++;
            if ((int'(ui.Start_S) + int'(ui.Stop_S) + int'(ui.Reset_S)) > 1 ||
                (ui.Start_S && p_start) || (ui.Stop_S && p_stop) || (ui.Reset_S && p_reset)) begin
                errors++;
                $display("FAIL pulse_shape: start/stop/reset=%b%b%b prev=%b%b%b, required a single one-cycle pulse",
                         ui.Start_S, ui.Stop_S, ui.Reset_S, p_start, p_stop, p_reset);
            end
        end
        act_start += int'(ui.Start_S);
        act_stop  += int'(ui.Stop_S);
        act_reset += int'(ui.Reset_S);
        p_start = ui.Start_S;
        p_stop  = ui.Stop_S;
        p_reset = ui.Reset_S;
    end

    // scoreboard consumer
    always begin
        snap_t exp_s, got_s;
        @(settled);
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty, required one queued expectation", cur_name);
        end else begin
            exp_s = sb.pop_front();
            got_s = snap_dut();
            if (got_s !== exp_s) begin
                errors++;
                $display("FAIL %s: snapshot got %h required %h", cur_name, got_s, exp_s);
            end
        end
    end

    // btns = {down, up, mode}; hold in cycles, release, then settle and check
    task automatic press(input logic [2:0] btns, input int hold);
        @(negedge Clock_5K);
        {ui.Btn_Down, ui.Btn_Up, ui.Btn_Mode} = btns;
        if (hold > DEB) model_press(btns);
        sb.push_back(snap_model());
        repeat (hold) @(negedge Clock_5K);
        {ui.Btn_Down, ui.Btn_Up, ui.Btn_Mode} = 3'b000;
        repeat (DEB + 8) @(negedge Clock_5K);
        -> settled;
        #1;
    endtask

    task automatic test_reset();
        cur_name = "reset_state";
        {ui.Btn_Down, ui.Btn_Up, ui.Btn_Mode} = 3'b000;
        Reset = 1'b0;
        model_reset();
        repeat (3) @(negedge Clock_5K);
        Reset = 1'b1;
        sb.push_back(snap_model());
        -> settled;
        #1;
        for (int i = 0; i < 100; i++) begin
            @(negedge Clock_5K);
            checks++;
            if (ui.Control !== 1'b1 || ui.Mode_State !== 4'd0 || ui.LoadTime !== 1'b0 ||
                ui.LoadAlm !== 1'b0 || ui.SetHours !== 4'd12 || ui.SetMins !== 6'd0 ||
                ui.Start_S !== 1'b0 || ui.Stop_S !== 1'b0 || ui.Reset_S !== 1'b0) begin
                errors++;
                $display("FAIL idle_cycle_%0d: ctl=%b st=%0d lt=%b la=%b h=%0d m=%0d pulses=%b%b%b, required 1/0/0/0/12/0/000",
                         i, ui.Control, ui.Mode_State, ui.LoadTime, ui.LoadAlm, ui.SetHours, ui.SetMins,
                         ui.Start_S, ui.Stop_S, ui.Reset_S);
            end
        end
    endtask

    task automatic test_mode_timing();
        cur_name = "mode_single_step";
        @(negedge Clock_5K);
        ui.Btn_Mode = 1'b1;
        model_press(3'b001);
        sb.push_back(snap_model());
        @(posedge Clock_5K);                 // edge E
        repeat (6) @(posedge Clock_5K);
        #1;
        checks++;
        if (ui.Mode_State !== 4'd0 || ui.LoadTime !== 1'b0) begin
            errors++;
            $display("FAIL mode_early_E6: state=%0d lt=%b, required 0/0", ui.Mode_State, ui.LoadTime);
        end
        @(posedge Clock_5K);
        #1;
        checks++;
        if (ui.Mode_State !== 4'd1 || ui.LoadTime !== 1'b1) begin
            errors++;
            $display("FAIL mode_at_E7: state=%0d lt=%b, required 1/1", ui.Mode_State, ui.LoadTime);
        end
        repeat (12) @(negedge Clock_5K);
        ui.Btn_Mode = 1'b0;
        repeat (DEB + 8) @(negedge Clock_5K);
        -> settled;
        #1;
    endtask

    task automatic test_hours_minutes();
        for (int i = 0; i < 13; i++) begin
            cur_name = $sformatf("hour_up_%0d", i);
            press(3'b010, DEB + 4);
        end
        cur_name = "to_t_min";
        press(3'b001, DEB + 4);
        cur_name = "min_down_wrap";
        press(3'b100, DEB + 4);
    endtask

    task automatic test_glitch();
        cur_name = "to_t_sec";
        press(3'b001, DEB + 4);
        cur_name = "sec_glitch";
        press(3'b010, 3);
        cur_name = "sec_up";
        press(3'b010, DEB + 4);
        cur_name = "sec_down";
        press(3'b100, DEB + 4);
    endtask

    task automatic test_stopwatch();
        for (int i = 0; i < 5; i++) begin
            cur_name = $sformatf("advance_to_sw_%0d", i);
            press(3'b001, DEB + 4);
        end
        cur_name = "sw_clear_stopped";
        press(3'b100, DEB + 4);
        cur_name = "sw_start";
        press(3'b010, DEB + 4);
        cur_name = "sw_down_running";
        press(3'b100, DEB + 4);
        cur_name = "sw_leave_running";
        @(negedge Clock_5K);
        ui.Btn_Mode = 1'b1;
        model_press(3'b001);
        sb.push_back(snap_model());
        @(posedge Clock_5K);
        repeat (6) @(posedge Clock_5K);
        #1;
        checks++;
        if (ui.Mode_State !== 4'd8 || ui.Control !== 1'b0 || ui.Stop_S !== 1'b0) begin
            errors++;
            $display("FAIL sw_exit_E6: state=%0d ctl=%b stop=%b, required 8/0/0",
                     ui.Mode_State, ui.Control, ui.Stop_S);
        end
        @(posedge Clock_5K);
        #1;
        checks++;
        if (ui.Mode_State !== 4'd0 || ui.Control !== 1'b1 || ui.Stop_S !== 1'b1) begin
            errors++;
            $display("FAIL sw_exit_E7: state=%0d ctl=%b stop=%b, required 0/1/1",
                     ui.Mode_State, ui.Control, ui.Stop_S);
        end
        repeat (4) @(negedge Clock_5K);
        ui.Btn_Mode = 1'b0;
        repeat (DEB + 8) @(negedge Clock_5K);
        -> settled;
        #1;
    endtask

    task automatic test_alarm();
        for (int i = 0; i < 5; i++) begin
            cur_name = $sformatf("advance_to_a_hour_%0d", i);
            press(3'b001, DEB + 4);
        end
        for (int i = 0; i < 5; i++) begin
            cur_name = $sformatf("alarm_hour_down_%0d", i);
            press(3'b100, DEB + 4);
        end
        cur_name = "to_a_min";
        press(3'b001, DEB + 4);
        for (int i = 0; i < 30; i++) begin
            cur_name = $sformatf("alarm_min_up_%0d", i);
            press(3'b010, DEB + 4);
        end
        cur_name = "to_a_ampm";
        press(3'b001, DEB + 4);
        cur_name = "alarm_pm";
        press(3'b010, DEB + 4);
        cur_name = "to_sw_idle";
        press(3'b001, DEB + 4);
        cur_name = "sw_exit_idle";
        press(3'b001, DEB + 4);
        cur_name = "alarm_enable";
        press(3'b010, DEB + 4);
    endtask

    task automatic test_back_to_back();
        cur_name = "up_down_together";
        press(3'b110, DEB + 4);
        cur_name = "mode_up_together";
        press(3'b011, DEB + 4);
        cur_name = "mode_down_together";
        press(3'b101, DEB + 4);
    endtask

    task automatic test_reset_mid_edit();
        cur_name = "min_up_wrap";
        press(3'b010, DEB + 4);
        cur_name = "min_up_again";
        press(3'b010, DEB + 4);
        cur_name = "reset_mid_edit";
        @(negedge Clock_5K);
        Reset = 1'b0;
        @(negedge Clock_5K);
        Reset = 1'b1;
        model_reset();
        sb.push_back(snap_model());
        repeat (3) @(negedge Clock_5K);
        -> settled;
        #1;
    endtask

    initial begin
        test_reset();
        test_mode_timing();
        test_hours_minutes();
        test_glitch();
        test_stopwatch();
        test_alarm();
        test_back_to_back();
        test_reset_mid_edit();
        repeat (5) @(negedge Clock_5K);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule
